// File: rtl/read_ld_stream_pkg.sv
// Shared constants, state encoding and slot-index helper for the activation read path.
// The activation SRAM word packs ACT_PER_ADDR quadrant positions for each of CH_NUM channels.
package read_ld_stream_pkg;

  localparam int CH_NUM       = 24;
  localparam int ACT_PER_ADDR = 4;
  localparam int BW_PER_ACT   = 16;
  localparam int W            = CH_NUM * ACT_PER_ADDR * BW_PER_ACT;
  localparam int SLOT_NUM     = CH_NUM * ACT_PER_ADDR;
  localparam int CH_BW        = 5;
  localparam int POS_BW       = 2;
  localparam int SLOT_BW      = 7;

  localparam logic [POS_BW-1:0] POS_LU = 2'd0;
  localparam logic [POS_BW-1:0] POS_RU = 2'd1;
  localparam logic [POS_BW-1:0] POS_LD = 2'd2;
  localparam logic [POS_BW-1:0] POS_RD = 2'd3;

  localparam logic [CH_BW-1:0] CH_LAST = CH_BW'(CH_NUM - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_CAPT   = 3'd2,
    ST_STREAM = 3'd3,
    ST_FIN    = 3'd4
  } state_e;

  // With four positions per channel, slot = ch*4 + pos is a plain concatenation.
  function automatic logic [SLOT_BW-1:0] slot_index(input logic [CH_BW-1:0]  ch,
                                                    input logic [POS_BW-1:0] pos);
    return {ch, pos};
  endfunction

endpackage

// File: rtl/read_ld_stream_act_slot_mux.sv
// Selects one activation slot (channel, quadrant position) out of a packed SRAM word.
// Slot 0 sits at the MSB end of the word.
module act_slot_mux
  import read_ld_stream_pkg::*;
(
  input  logic [W-1:0]          word_buf,
  input  logic [CH_BW-1:0]      ch_idx,
  input  logic [POS_BW-1:0]     pos_sel,
  output logic [BW_PER_ACT-1:0] act
);

  logic [BW_PER_ACT-1:0] slot_a [SLOT_NUM];
  logic [SLOT_BW-1:0]    slot_s;

  assign slot_s = slot_index(ch_idx, pos_sel);

  // Unpack the word into MSB-first slots.
  always_comb begin
    for (int i = 0; i < SLOT_NUM; i++) begin
      slot_a[i] = word_buf[W-1-i*BW_PER_ACT -: BW_PER_ACT];
    end
  end

  // Channel indices beyond CH_NUM-1 yield zero rather than an out-of-range read.
  always_comb begin
    if (slot_s < SLOT_BW'(SLOT_NUM)) begin
      act = slot_a[slot_s];
    end else begin
      act = {BW_PER_ACT{1'b0}};
    end
  end

endmodule

// File: rtl/read_ld_stream.sv
// Fetches packed activation words from SRAM and streams one quadrant position per channel
// under a valid/ready handshake. One word is read, captured, then drained before the next.
module read_ld_stream
  import read_ld_stream_pkg::*;
#(
  parameter int ADDR_BW = 10,
  parameter int CNT_BW  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_BW-1:0]    base_addr,
  input  logic [CNT_BW-1:0]     num_words,
  input  logic [POS_BW-1:0]     pos_sel,
  output logic                  sram_rd_en,
  output logic [ADDR_BW-1:0]    sram_raddr,
  input  logic [W-1:0]          sram_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BW_PER_ACT-1:0] out_data,
  output logic [CH_BW-1:0]      out_ch,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  state_e              state_q, state_d;
  logic [ADDR_BW-1:0]  base_q, base_d;
  logic [CNT_BW-1:0]   num_q, num_d;
  logic [POS_BW-1:0]   pos_q, pos_d;
  logic [CNT_BW-1:0]   word_idx_q, word_idx_d;
  logic [CH_BW-1:0]    ch_idx_q, ch_idx_d;
  logic [W-1:0]        word_buf_q, word_buf_d;
  logic                last_word_s;
  logic [BW_PER_ACT-1:0] act_s;

  logic                  sram_rd_en_q, sram_rd_en_d;
  logic [ADDR_BW-1:0]    sram_raddr_q, sram_raddr_d;
  logic                  out_valid_q, out_valid_d;
  logic [BW_PER_ACT-1:0] out_data_q, out_data_d;
  logic [CH_BW-1:0]      out_ch_q, out_ch_d;
  logic                  out_last_q, out_last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  assign last_word_s = (word_idx_q == (num_q - CNT_BW'(1)));

  // Outputs are registered from next-state values, so the mux reads the next word buffer.
  act_slot_mux u_act_slot_mux (
    .word_buf (word_buf_d),
    .ch_idx   (ch_idx_d),
    .pos_sel  (pos_d),
    .act      (act_s)
  );

  // State, job fields, indices and the captured word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      base_q     <= {ADDR_BW{1'b0}};
      num_q      <= {CNT_BW{1'b0}};
      pos_q      <= {POS_BW{1'b0}};
      word_idx_q <= {CNT_BW{1'b0}};
      ch_idx_q   <= {CH_BW{1'b0}};
      word_buf_q <= {W{1'b0}};
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      num_q      <= num_d;
      pos_q      <= pos_d;
      word_idx_q <= word_idx_d;
      ch_idx_q   <= ch_idx_d;
      word_buf_q <= word_buf_d;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    num_d      = num_q;
    pos_d      = pos_q;
    word_idx_d = word_idx_q;
    ch_idx_d   = ch_idx_q;
    word_buf_d = word_buf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (num_words == {CNT_BW{1'b0}}) begin
            state_d = ST_FIN;
          end else begin
            state_d    = ST_REQ;
            base_d     = base_addr;
            num_d      = num_words;
            pos_d      = pos_sel;
            word_idx_d = {CNT_BW{1'b0}};
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        state_d = ST_CAPT;
      end
      ST_CAPT: begin
        word_buf_d = sram_rdata;
        ch_idx_d   = {CH_BW{1'b0}};
        state_d    = ST_STREAM;
      end
      ST_STREAM: begin
        if (out_ready) begin
          if (ch_idx_q == CH_LAST) begin
            if (last_word_s) begin
              state_d = ST_FIN;
            end else begin
              state_d    = ST_REQ;
              word_idx_d = word_idx_q + CNT_BW'(1);
            end
          end else begin
            ch_idx_d = ch_idx_q + CH_BW'(1);
          end
        end else begin
          state_d = ST_STREAM;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode for the state being entered.
  always_comb begin
    sram_rd_en_d = 1'b0;
    sram_raddr_d = {ADDR_BW{1'b0}};
    out_valid_d  = 1'b0;
    out_data_d   = {BW_PER_ACT{1'b0}};
    out_ch_d     = {CH_BW{1'b0}};
    out_last_d   = 1'b0;
    busy_d       = 1'b1;
    done_d       = 1'b0;
    case (state_d)
      ST_IDLE: begin
        busy_d = 1'b0;
      end
      ST_REQ: begin
        sram_rd_en_d = 1'b1;
        sram_raddr_d = base_d + ADDR_BW'(word_idx_d);
      end
      ST_CAPT: begin
        busy_d = 1'b1;
      end
      ST_STREAM: begin
        out_valid_d = 1'b1;
        out_data_d  = act_s;
        out_ch_d    = ch_idx_d;
        out_last_d  = (ch_idx_d == CH_LAST) && (word_idx_d == (num_d - CNT_BW'(1)));
      end
      ST_FIN: begin
        done_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_rd_en_q <= 1'b0;
      sram_raddr_q <= {ADDR_BW{1'b0}};
      out_valid_q  <= 1'b0;
      out_data_q   <= {BW_PER_ACT{1'b0}};
      out_ch_q     <= {CH_BW{1'b0}};
      out_last_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      sram_rd_en_q <= sram_rd_en_d;
      sram_raddr_q <= sram_raddr_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_ch_q     <= out_ch_d;
      out_last_q   <= out_last_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign sram_rd_en = sram_rd_en_q;
  assign sram_raddr = sram_raddr_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_ch     = out_ch_q;
  assign out_last   = out_last_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_read_ld_stream.sv
// Randomized self-checking bench for read_ld_stream: an SRAM model plus a reference
// stream built directly from the slot layout rules.
module tb_read_ld_stream;
  import read_ld_stream_pkg::*;

  localparam int ADDR_BW = 10;
  localparam int CNT_BW  = 10;
  localparam int DEPTH   = 1 << ADDR_BW;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  start = 1'b0;
  logic [ADDR_BW-1:0]    base_addr = '0;
  logic [CNT_BW-1:0]     num_words = '0;
  logic [POS_BW-1:0]     pos_sel = '0;
  logic                  sram_rd_en;
  logic [ADDR_BW-1:0]    sram_raddr;
  logic [W-1:0]          sram_rdata = '0;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic [BW_PER_ACT-1:0] out_data;
  logic [CH_BW-1:0]      out_ch;
  logic                  out_last;
  logic                  busy;
  logic                  done;

  read_ld_stream #(.ADDR_BW(ADDR_BW), .CNT_BW(CNT_BW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .num_words(num_words), .pos_sel(pos_sel), .sram_rd_en(sram_rd_en),
    .sram_raddr(sram_raddr), .sram_rdata(sram_rdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [BW_PER_ACT-1:0] data;
    logic [CH_BW-1:0]      ch;
    logic                  last;
  } beat_t;

  logic [W-1:0] mem [int];
  beat_t obs_q [$];
  beat_t exp_q [$];
  int    rd_addr_q [$];
  int    done_cnt, done_cyc, last_acc_cyc, busy_cyc, valid_cyc, stall_err;
  int    errors = 0;
  int    checks = 0;

  // SRAM model: data valid one cycle after the read strobe, all-ones otherwise.
  always @(posedge clk) begin
    if (sram_rd_en) sram_rdata <= mem.exists(int'(sram_raddr)) ? mem[int'(sram_raddr)] : {W{1'b0}};
    else            sram_rdata <= {W{1'b1}};
  end

  function automatic void fill_random(input int addr);
    logic [W-1:0] w;
    for (int k = 0; k < W/32; k++) w[k*32 +: 32] = $urandom;
    mem[addr] = w;
  endfunction

  function automatic void fill_pattern(input int addr);
    logic [W-1:0] w;
    for (int s = 0; s < SLOT_NUM; s++) w[W-1-s*BW_PER_ACT -: BW_PER_ACT] = 16'h0100 + 16'(s);
    mem[addr] = w;
  endfunction

  // Reference: every word in order, every channel, slot ch*4+pos from the MSB end.
  function automatic void build_expected(input int base, input int num, input int pos);
    beat_t b;
    logic [W-1:0] word;
    int addr, s;
    exp_q.delete();
    for (int w = 0; w < num; w++) begin
      addr = (base + w) % DEPTH;
      word = mem.exists(addr) ? mem[addr] : {W{1'b0}};
      for (int ch = 0; ch < CH_NUM; ch++) begin
        s = ch * ACT_PER_ADDR + pos;
        b.data = word[W-1-s*BW_PER_ACT -: BW_PER_ACT];
        b.ch   = 5'(ch);
        b.last = (w == num - 1) && (ch == CH_NUM - 1);
        exp_q.push_back(b);
      end
    end
  endfunction

  function automatic int beat_diffs();
    int n = 0;
    int m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) if (obs_q[i] !== exp_q[i]) n++;
    n += (obs_q.size() > exp_q.size()) ? obs_q.size() - exp_q.size() : exp_q.size() - obs_q.size();
    return n;
  endfunction

  // Runs one job and records what the DUT did; inj_cyc >= 0 pulses a second start mid-job.
  task automatic drive_job(input int base, input int num, input int pos, input int pct,
                           input int max_cyc, input int inj_cyc, input int inj_base, input int inj_pos);
    beat_t cur, prev;
    bit    prev_stall = 1'b0;
    obs_q.delete(); rd_addr_q.delete();
    done_cnt = 0; done_cyc = -10; last_acc_cyc = -10; busy_cyc = 0; valid_cyc = 0; stall_err = 0;
    prev = '0;
    @(negedge clk);
    start = 1'b1; base_addr = ADDR_BW'(base); num_words = CNT_BW'(num); pos_sel = POS_BW'(pos);
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      @(negedge clk);
      start = (cyc == inj_cyc);
      if (cyc == inj_cyc) begin
        base_addr = ADDR_BW'(inj_base); pos_sel = POS_BW'(inj_pos); num_words = CNT_BW'(5);
      end else begin
        base_addr = ADDR_BW'($urandom); pos_sel = POS_BW'($urandom); num_words = CNT_BW'($urandom);
      end
      out_ready = ($urandom_range(99) < pct);
      if (sram_rd_en) rd_addr_q.push_back(int'(sram_raddr));
      if (busy) busy_cyc++;
      if (out_valid) valid_cyc++;
      if (done) begin done_cnt++; done_cyc = cyc; end
      cur.data = out_data; cur.ch = out_ch; cur.last = out_last;
      if (prev_stall && (!out_valid || cur !== prev)) stall_err++;
      if (out_valid && out_ready) begin obs_q.push_back(cur); last_acc_cyc = cyc; end
      prev_stall = out_valid && !out_ready;
      prev = cur;
      if (done_cnt > 0 && cyc >= done_cyc + 2) break;
    end
    start = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (sram_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b want 0", sram_rd_en); end
    checks++; if (sram_raddr !== '0) begin errors++; $display("FAIL reset_raddr got %0d want 0", sram_raddr); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if ({out_data, out_ch, out_last} !== '0) begin errors++; $display("FAIL reset_outs got %h/%0d/%b want 0", out_data, out_ch, out_last); end
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL reset_busy_done got %b%b want 00", busy, done); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_word();
    fill_pattern(5);
    drive_job(5, 1, 2, 100, 200, -1, 0, 0);
    build_expected(5, 1, 2);
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL single_done_cnt got %0d want 1", done_cnt); end
    checks++; if (rd_addr_q.size() !== 1 || rd_addr_q[0] !== 5) begin errors++; $display("FAIL single_reads got %0d reads first %0d want 1 at 5", rd_addr_q.size(), (rd_addr_q.size() > 0) ? rd_addr_q[0] : -1); end
    checks++; if (beat_diffs() !== 0) begin errors++; $display("FAIL single_stream got %0d bad beats of %0d want 0", beat_diffs(), obs_q.size()); end
    checks++; if (obs_q.size() !== 24 || obs_q[0].data !== 16'h0102 || obs_q[23].data !== 16'h015E) begin errors++; $display("FAIL single_ends got size %0d want 24 with 0102..015E", obs_q.size()); end
    checks++; if (done_cyc !== last_acc_cyc + 1) begin errors++; $display("FAIL single_done_time got %0d want %0d", done_cyc, last_acc_cyc + 1); end
    checks++; if (busy_cyc !== CH_NUM + 3) begin errors++; $display("FAIL single_busy_cycles got %0d want %0d", busy_cyc, CH_NUM + 3); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_wrap();
    fill_random(1022); fill_random(1023); fill_random(0);
    drive_job(1022, 3, 0, 100, 400, -1, 0, 0);
    build_expected(1022, 3, 0);
    checks++; if (rd_addr_q.size() !== 3 || rd_addr_q[0] !== 1022 || rd_addr_q[1] !== 1023 || rd_addr_q[2] !== 0) begin errors++; $display("FAIL wrap_reads got %0d reads want 1022,1023,0", rd_addr_q.size()); end
    checks++; if (obs_q.size() !== 72) begin errors++; $display("FAIL wrap_count got %0d want 72", obs_q.size()); end
    checks++; if (beat_diffs() !== 0) begin errors++; $display("FAIL wrap_stream got %0d bad beats want 0", beat_diffs()); end
    checks++; if (busy_cyc !== 3 * (CH_NUM + 2) + 1) begin errors++; $display("FAIL wrap_busy_cycles got %0d want %0d", busy_cyc, 3 * (CH_NUM + 2) + 1); end
  endtask

  task automatic test_backpressure();
    int base = $urandom_range(DEPTH - 1);
    int pos  = $urandom_range(3);
    for (int w = 0; w < 2; w++) fill_random((base + w) % DEPTH);
    drive_job(base, 2, pos, 50, 2000, -1, 0, 0);
    build_expected(base, 2, pos);
    checks++; if (beat_diffs() !== 0) begin errors++; $display("FAIL bp_stream got %0d bad beats of %0d want 0", beat_diffs(), obs_q.size()); end
    checks++; if (stall_err !== 0) begin errors++; $display("FAIL bp_stable got %0d unstable stalls want 0", stall_err); end
    checks++; if (done_cnt !== 1 || done_cyc !== last_acc_cyc + 1) begin errors++; $display("FAIL bp_done got cnt %0d at %0d want 1 at %0d", done_cnt, done_cyc, last_acc_cyc + 1); end
  endtask

  task automatic test_zero_words();
    drive_job($urandom_range(DEPTH - 1), 0, 2, 100, 50, -1, 0, 0);
    checks++; if (rd_addr_q.size() !== 0) begin errors++; $display("FAIL zero_reads got %0d want 0", rd_addr_q.size()); end
    checks++; if (valid_cyc !== 0) begin errors++; $display("FAIL zero_valid got %0d want 0", valid_cyc); end
    checks++; if (busy_cyc !== 1 || done_cnt !== 1) begin errors++; $display("FAIL zero_busy_done got busy %0d done %0d want 1 1", busy_cyc, done_cnt); end
  endtask

  task automatic test_start_ignored();
    fill_random(100); fill_random(101); fill_random(200); fill_random(201);
    drive_job(100, 2, 3, 100, 400, 10, 200, 1);
    build_expected(100, 2, 3);
    checks++; if (rd_addr_q.size() !== 2 || rd_addr_q[0] !== 100 || rd_addr_q[1] !== 101) begin errors++; $display("FAIL ign_reads got %0d reads want 100,101", rd_addr_q.size()); end
    checks++; if (beat_diffs() !== 0) begin errors++; $display("FAIL ign_stream got %0d bad beats want 0", beat_diffs()); end
    checks++; if (done_cnt !== 1 || busy_cyc !== 2 * (CH_NUM + 2) + 1) begin errors++; $display("FAIL ign_done got done %0d busy %0d want 1 %0d", done_cnt, busy_cyc, 2 * (CH_NUM + 2) + 1); end
  endtask

  task automatic test_reset_midjob();
    int  base = $urandom_range(DEPTH - 1);
    int  rd_cnt = 0;
    int  done_seen = 0;
    bit  found = 1'b0;
    for (int w = 0; w < 3; w++) fill_random((base + w) % DEPTH);
    @(negedge clk);
    start = 1'b1; base_addr = ADDR_BW'(base); num_words = CNT_BW'(3); pos_sel = 2'd2; out_ready = 1'b1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (sram_rd_en) rd_cnt++;
      if (rd_cnt == 2 && out_valid && out_ch == 5'd5) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin errors++; $display("FAIL rst_reach_word2 got reads %0d want stream of word 2", rd_cnt); end
    rst_n = 1'b0;
    #1;
    checks++; if ({sram_rd_en, sram_raddr, out_valid, out_data, out_ch, out_last, busy, done} !== '0) begin errors++; $display("FAIL rst_outputs got valid %b busy %b data %h want all 0", out_valid, busy, out_data); end
    repeat (2) begin @(negedge clk); if (done) done_seen++; end
    rst_n = 1'b1;
    repeat (4) begin @(negedge clk); if (done || busy) done_seen++; end
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL rst_no_done got %0d done/busy cycles want 0", done_seen); end
    fill_pattern(5);
    drive_job(5, 1, 2, 100, 200, -1, 0, 0);
    build_expected(5, 1, 2);
    checks++; if (rd_addr_q.size() !== 1 || beat_diffs() !== 0 || done_cnt !== 1) begin errors++; $display("FAIL rst_fresh_job got reads %0d bad %0d done %0d want 1 0 1", rd_addr_q.size(), beat_diffs(), done_cnt); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_wrap();
    test_backpressure();
    test_zero_words();
    test_start_ignored();
    test_backpressure();
    test_reset_midjob();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
